ins_prefetch: RTL and testbench
===============================

Name: ins_prefetch

Overview:
- Instruction prefetch queue upstream of the CPU control FSM.
- Fetches 16-bit words in order from program memory over a request/grant/response port and buffers them in a small FIFO.
- Presents the current instruction word plus the following word (SET immediate) to the CPU, which consumes 0, 1 or 2 words per cycle.
- Redirect flushes the queue and restarts fetch at a new PC; in-flight responses are discarded.

Parameters:
- ADDR_W, 16: program address width in words.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 0: fetch address after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- mem_req  out  1  fetch request valid
- mem_addr  out  ADDR_W  fetch word address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response word valid; responses return in request order
- mem_rdata  in  16  response word
- redirect  in  1  flush queue and restart fetch
- redirect_pc  in  ADDR_W  new fetch address
- consume  in  2  words retired this cycle: 0, 1 or 2; value 3 is illegal
- ins_valid  out  1  at least 1 word buffered
- ins_word  out  16  FIFO head word
- ins_pc  out  ADDR_W  address of the head word
- imm_valid  out  1  at least 2 words buffered
- imm_word  out  16  word after the head
- err_underflow  out  1  sticky; consume exceeded the buffered word count

Behaviour:
- Reset (asynchronous):
  - fetch_pc=RESET_PC, head_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop=0.
  - All outputs 0, except mem_addr=RESET_PC.
- Credit rule: mem_req=1 iff (occupancy + outstanding) < DEPTH and redirect=0. mem_addr=fetch_pc.
- Request accepted (mem_req & mem_gnt):
  - fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W.
  - outstanding increments.
- Response (mem_rvalid):
  - outstanding decrements.
  - If drop>0: word discarded, drop decrements.
  - Otherwise: word written at FIFO tail; it is visible on ins_*/imm_* the next cycle (no bypass).
- Consume:
  - Head advances by consume; ins_pc advances by consume, modulo 2^ADDR_W.
  - Outputs are combinational from the FIFO head: ins_word=entry[head], imm_word=entry[head+1].
  - An output word is 0 when its valid is 0.
- Illegal consume:
  - consume > occupancy, or consume=3: err_underflow <= 1 (sticky until rst).
  - Head advances only by min(consume, occupancy), capped at 2.
- Simultaneous write and consume in the same cycle are both honoured; occupancy changes by (written - consumed).
- Redirect (highest priority):
  - FIFO emptied; consume ignored that cycle.
  - fetch_pc <= redirect_pc; head_pc <= redirect_pc.
  - drop <= outstanding after this cycle's grant and response updates, i.e. every request still in flight is discarded.
  - mem_req forced 0 that cycle.
  - First new request issues the following cycle.
- Full: occupancy=DEPTH gives mem_req=0; consume frees entries, and mem_req may reassert the next cycle.
- Wrap-around: fetch at address 2^ADDR_W-1 proceeds to address 0 with no error.
- Steady state with a zero-wait memory (gnt=1, rvalid one cycle after grant) sustains one word per cycle.
- Latency:
  - Redirect to ins_valid = 3 cycles: request at cycle 1, response at cycle 2, visible at cycle 3.
  - imm_valid follows 1 cycle after ins_valid.

Optional Feature:
- Macro: INS_PREFETCH_STATS_EN.
- When defined, adds three outputs, each saturating at 0xFFFF and cleared by rst:
  - stat_flushes (16): count of redirects.
  - stat_starve (16): cycles with ins_valid=0 and redirect=0.
  - stat_dropped (16): count of discarded responses.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then zero-wait memory returning mem_rdata=address+0x100 -> cycle 3: ins_valid=1, ins_word=0x0100, ins_pc=0; cycle 4: imm_word=0x0101.
- Fill with consume=0, DEPTH=4 -> occupancy reaches 4, mem_req held 0, no more than 4 grants total; consume=2 -> mem_req reasserts next cycle.
- consume=2 every cycle against a 1-word/cycle memory -> err_underflow stays 0 only while imm_valid=1; first consume=2 with only 1 word buffered -> err_underflow=1 and stays 1.
- Redirect to 0x0040 with 2 responses in flight, memory latency 3 -> both stale words dropped; first ins_word=0x0140, ins_pc=0x0040.
- Redirect to 0xFFFE, consume 1 per cycle -> ins_pc sequence FFFE, FFFF, 0000, 0001.
- Assert rst mid-stream with words buffered and requests outstanding -> all outputs 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ins_prefetch.sv
// ins_prefetch: instruction prefetch queue feeding the CPU control FSM.
// Fetches 16-bit words in order over a req/gnt/rvalid port into a DEPTH-entry
// FIFO and presents the head word plus the following word (SET immediate).
// The CPU retires 0, 1 or 2 words per cycle. Redirect flushes the queue and
// restarts fetch; responses still in flight at that point are discarded.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_req/mem_addr    fetch request and word address
//   mem_gnt             request accepted this cycle
//   mem_rvalid/rdata    in-order response word
//   redirect/redirect_pc  flush and restart fetch at redirect_pc
//   consume             words retired this cycle (3 is illegal)
//   ins_valid/word/pc   FIFO head word and its address
//   imm_valid/imm_word  word following the head
//   err_underflow       sticky: consume exceeded the buffered word count
//
// Optional build macro INS_PREFETCH_STATS_EN adds saturating counters
// stat_flushes, stat_starve and stat_dropped.
module ins_prefetch #(
  parameter int unsigned         ADDR_W   = 16,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [1:0]        consume,
  output logic              ins_valid,
  output logic [15:0]       ins_word,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              imm_valid,
  output logic [15:0]       imm_word,
  output logic              err_underflow
`ifdef INS_PREFETCH_STATS_EN
  ,
  output logic [15:0]       stat_flushes,
  output logic [15:0]       stat_starve,
  output logic [15:0]       stat_dropped
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [15:0]       fifo_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, outst_q, drop_q;
  logic [ADDR_W-1:0] fetch_pc_q, head_pc_q;
  logic              err_q;

  logic [CW:0]       inflight_c;
  logic              req_fire_c, keep_c, underflow_c;
  logic [1:0]        cons_req_c, cons_eff_c;
  logic [CW-1:0]     count_nxt_c, outst_nxt_c;
  logic [PW-1:0]     imm_idx_c;

  // Credit: buffered plus in-flight words never exceed the FIFO depth.
  assign inflight_c = {1'b0, count_q} + {1'b0, outst_q};
  assign mem_req    = !rst && !redirect && (inflight_c < (CW+1)'(DEPTH));
  assign mem_addr   = fetch_pc_q;
  assign req_fire_c = mem_req && mem_gnt;
  assign keep_c     = mem_rvalid && (drop_q == '0) && !redirect;

  // Consume clamped to what is buffered and to two words.
  always_comb begin
    cons_req_c  = (consume == 2'd3) ? 2'd2 : consume;
    cons_eff_c  = cons_req_c;
    if (count_q < CW'(cons_req_c)) begin
      cons_eff_c = 2'(count_q);
    end
    underflow_c = (consume == 2'd3) || (CW'(consume) > count_q);
    count_nxt_c = count_q + CW'(keep_c) - CW'(cons_eff_c);
    outst_nxt_c = outst_q + CW'(req_fire_c) - CW'(mem_rvalid);
  end

  // Queue pointers, fetch/head addresses, credit and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      err_q      <= 1'b0;
    end else begin
      outst_q <= outst_nxt_c;
      if (redirect) begin
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        fetch_pc_q <= redirect_pc;
        head_pc_q  <= redirect_pc;
        drop_q     <= outst_nxt_c;
      end else begin
        if (req_fire_c) begin
          fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
        end
        if (mem_rvalid && (drop_q != '0)) begin
          drop_q <= drop_q - CW'(1);
        end
        if (keep_c) begin
          tail_q <= tail_q + PW'(1);
        end
        head_q    <= head_q + PW'(cons_eff_c);
        head_pc_q <= head_pc_q + ADDR_W'(cons_eff_c);
        count_q   <= count_nxt_c;
        if (underflow_c) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Word storage; contents are masked by the valid flags, so no reset needed.
  always_ff @(posedge clk) begin
    if (keep_c) begin
      fifo_q[tail_q] <= mem_rdata;
    end
  end

  assign imm_idx_c     = head_q + PW'(1);
  assign ins_valid     = (count_q != '0);
  assign imm_valid     = (count_q >= CW'(2));
  assign ins_word      = ins_valid ? fifo_q[head_q] : 16'h0000;
  assign imm_word      = imm_valid ? fifo_q[imm_idx_c] : 16'h0000;
  assign ins_pc        = head_pc_q;
  assign err_underflow = err_q;

`ifdef INS_PREFETCH_STATS_EN
  logic drop_event_c;
  assign drop_event_c = mem_rvalid && (redirect || (drop_q != '0));

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flushes <= '0;
      stat_starve  <= '0;
      stat_dropped <= '0;
    end else begin
      if (redirect && (stat_flushes != 16'hFFFF)) begin
        stat_flushes <= stat_flushes + 16'd1;
      end
      if (!ins_valid && !redirect && (stat_starve != 16'hFFFF)) begin
        stat_starve <= stat_starve + 16'd1;
      end
      if (drop_event_c && (stat_dropped != 16'hFFFF)) begin
        stat_dropped <= stat_dropped + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ins_prefetch.sv
// Directed bench for ins_prefetch: a memory model returns address+0x100 with a
// programmable latency; stimulus pushes the words it retires into a scoreboard
// queue and a monitor compares them whenever the CPU consumes a valid word.
module tb_ins_prefetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [1:0]  consume;
  logic        ins_valid;
  logic [15:0] ins_word;
  logic [15:0] ins_pc;
  logic        imm_valid;
  logic [15:0] imm_word;
  logic        err_underflow;
`ifdef INS_PREFETCH_STATS_EN
  logic [15:0] stat_flushes, stat_starve, stat_dropped;
`endif

  ins_prefetch dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .consume      (consume),
    .ins_valid    (ins_valid),
    .ins_word     (ins_word),
    .ins_pc       (ins_pc),
    .imm_valid    (imm_valid),
    .imm_word     (imm_word),
`ifdef INS_PREFETCH_STATS_EN
    .stat_flushes (stat_flushes),
    .stat_starve  (stat_starve),
    .stat_dropped (stat_dropped),
`endif
    .err_underflow(err_underflow)
  );

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } exp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] due;
  } pend_t;

  exp_t  sbq[$];
  pend_t pend[$];
  int    total = 0;
  int    bad = 0;
  int    grant_cnt = 0;
  int    lat = 1;
  int    cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: grants every request, answers lat cycles later with addr+0x100.
  initial begin
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        pend.delete();
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
      end else if (pend.size() != 0 && pend[0].due == 32'(cyc)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend[0].addr + 16'h0100;
        void'(pend.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'hDEAD;
      end
      @(negedge clk);
      if (mem_req && mem_gnt) begin
        pend.push_back('{addr: mem_addr, due: 32'(cyc + lat)});
        grant_cnt++;
      end
    end
  end

  // Monitor: every retired word must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && !redirect && consume != 2'd0 && ins_valid) begin
      if (sbq.size() == 0) begin
        chk("sb_underrun", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_ins_word", 32'(ins_word), 32'(e.word));
        chk("sb_ins_pc", 32'(ins_pc), 32'(e.pc));
        if (consume == 2'd2 && imm_valid) begin
          if (sbq.size() == 0) begin
            chk("sb_underrun_imm", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("sb_imm_word", 32'(imm_word), 32'(e.word));
          end
        end
      end
    end
  end

  task automatic step(input logic [1:0] c, input logic r, input logic [15:0] pc);
    @(posedge clk); #1;
    consume     = c;
    redirect    = r;
    redirect_pc = pc;
  endtask

  task automatic push(input logic [15:0] a);
    sbq.push_back('{word: a + 16'h0100, pc: a});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
    chk({tag, "_ins_word"}, 32'(ins_word), 32'd0);
    chk({tag, "_ins_pc"}, 32'(ins_pc), 32'd0);
    chk({tag, "_imm_valid"}, 32'(imm_valid), 32'd0);
    chk({tag, "_imm_word"}, 32'(imm_word), 32'd0);
    chk({tag, "_err"}, 32'(err_underflow), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; consume = 2'd0; redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");

    // Release reset before cycle 0: first request issues in cycle 0.
    @(posedge clk); #3; rst = 1'b0;
    @(negedge clk);
    chk("c0_mem_req", 32'(mem_req), 32'd1);
    chk("c0_mem_addr", 32'(mem_addr), 32'd0);
    step(0, 0, 0); @(negedge clk);
    chk("c1_ins_valid", 32'(ins_valid), 32'd0);
    step(0, 0, 0); @(negedge clk);
    chk("c2_ins_valid", 32'(ins_valid), 32'd1);
    chk("c2_ins_word", 32'(ins_word), 32'h0100);
    chk("c2_ins_pc", 32'(ins_pc), 32'h0000);
    chk("c2_imm_valid", 32'(imm_valid), 32'd0);
    step(0, 0, 0); @(negedge clk);
    chk("c3_imm_valid", 32'(imm_valid), 32'd1);
    chk("c3_imm_word", 32'(imm_word), 32'h0101);

    // Fill: credit stops requests at DEPTH words.
    repeat (4) step(0, 0, 0);
    @(negedge clk);
    chk("full_mem_req", 32'(mem_req), 32'd0);
    chk("full_grants", 32'(grant_cnt), 32'd4);
    step(2, 0, 0); push(16'h0000); push(16'h0001); @(negedge clk);
    chk("full_consume_req", 32'(mem_req), 32'd0);
    step(0, 0, 0); @(negedge clk);
    chk("refill_mem_req", 32'(mem_req), 32'd1);
    chk("refill_mem_addr", 32'(mem_addr), 32'h0004);
    repeat (4) step(0, 0, 0);

    // Double consume drains faster than a 1-word/cycle memory refills.
    step(2, 0, 0); push(16'h0002); push(16'h0003); @(negedge clk);
    chk("uf0_imm_valid", 32'(imm_valid), 32'd1);
    chk("uf0_err", 32'(err_underflow), 32'd0);
    step(2, 0, 0); push(16'h0004); push(16'h0005); @(negedge clk);
    chk("uf1_imm_valid", 32'(imm_valid), 32'd1);
    chk("uf1_err", 32'(err_underflow), 32'd0);
    step(0, 0, 0); @(negedge clk);
    chk("uf2_ins_valid", 32'(ins_valid), 32'd0);
    chk("uf2_err", 32'(err_underflow), 32'd0);
    step(2, 0, 0); push(16'h0006); @(negedge clk);
    chk("uf3_ins_valid", 32'(ins_valid), 32'd1);
    chk("uf3_imm_valid", 32'(imm_valid), 32'd0);
    chk("uf3_err", 32'(err_underflow), 32'd0);
    step(0, 0, 0); @(negedge clk);
    chk("uf4_err", 32'(err_underflow), 32'd1);
    repeat (5) step(0, 0, 0);
    @(negedge clk);
    chk("uf_sticky", 32'(err_underflow), 32'd1);

    // Redirect with two stale responses in flight, memory latency 3.
    lat = 3;
    step(2, 0, 0); push(16'h0007); push(16'h0008);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 16'h0040); @(negedge clk);
    chk("rd_mem_req", 32'(mem_req), 32'd0);
    step(0, 0, 0); @(negedge clk);
    chk("rd1_mem_req", 32'(mem_req), 32'd1);
    chk("rd1_mem_addr", 32'(mem_addr), 32'h0040);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0); @(negedge clk);
    chk("rd_stale_dropped", 32'(ins_valid), 32'd0);
    step(1, 0, 0); push(16'h0040); @(negedge clk);
    chk("rd_ins_word", 32'(ins_word), 32'h0140);
    chk("rd_ins_pc", 32'(ins_pc), 32'h0040);
    repeat (12) step(0, 0, 0);
    lat = 1;

    // Redirect near the top of the address space; pc wraps to 0.
    step(0, 1, 16'hFFFE); @(negedge clk);
    chk("wr_mem_req", 32'(mem_req), 32'd0);
    step(0, 0, 0); @(negedge clk);
    chk("wr1_mem_addr", 32'(mem_addr), 32'hFFFE);
    step(0, 0, 0); @(negedge clk);
    chk("wr2_ins_valid", 32'(ins_valid), 32'd0);
    step(1, 0, 0); push(16'hFFFE); @(negedge clk);
    chk("wr3_ins_valid", 32'(ins_valid), 32'd1);
    step(1, 0, 0); push(16'hFFFF); @(negedge clk);
    chk("wr4_ins_valid", 32'(ins_valid), 32'd1);
    step(1, 0, 0); push(16'h0000); @(negedge clk);
    chk("wr5_ins_valid", 32'(ins_valid), 32'd1);
    step(1, 0, 0); push(16'h0001); @(negedge clk);
    chk("wr6_ins_valid", 32'(ins_valid), 32'd1);

    // Reset mid-stream: outputs clear immediately, fetch restarts at 0.
    @(posedge clk); #3; rst = 1'b1; consume = 2'd0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk);
    @(posedge clk); #3; rst = 1'b0;
    @(negedge clk);
    chk("rr0_mem_req", 32'(mem_req), 32'd1);
    chk("rr0_mem_addr", 32'(mem_addr), 32'd0);
    step(0, 0, 0);
    step(1, 0, 0); push(16'h0000); @(negedge clk);
    chk("rr2_ins_valid", 32'(ins_valid), 32'd1);
    step(1, 0, 0); push(16'h0001); @(negedge clk);
    step(0, 0, 0); @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
